// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a 16-entry note/duration song table as timed notes for a tone generator
module melody_sequencer #(
    parameter int TICK_DIV  = 1000000,
    parameter int GAP_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    output logic [2:0] note,
    output logic       note_on,
    output logic       busy,
    output logic       done,
    output logic [3:0] cur_addr
);
    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam int TW = (GW > 5) ? GW : 5;
    state_t        state_q, state_d;
    logic [3:0]    addr_q, addr_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    note_q, note_d;
    logic          note_on_q, note_on_d, done_q, done_d;
    logic [7:0]    mem [16];
    logic [7:0]    ent;
    logic          pre_wrap, last, advance, end_song;

    assign ent      = mem[addr_q];
    assign pre_wrap = pre_q == PW'(TICK_DIV - 1);
    assign note     = note_q;
    assign note_on  = note_on_q;
    assign done     = done_q;
    assign busy     = state_q != IDLE;
    assign cur_addr = addr_q;

    // Song table: writable only while idle, deliberately untouched by reset
    always_ff @(posedge clk)
        if (wr_en && state_q == IDLE) mem[wr_addr] <= wr_data;

    // Next state: segment timing, entry sequencing, end-of-song handling, stop override
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pre_d     = pre_wrap ? '0 : pre_q + PW'(1);
        tick_d    = tick_q + TW'(pre_wrap);
        note_d    = '0;
        note_on_d = 1'b0;
        done_d    = 1'b0;
        advance   = 1'b0;
        end_song  = 1'b0;
        last      = pre_wrap && (state_q == PLAY ? tick_q == TW'(ent[4:0] - 5'd1)
                                                 : tick_q == TW'(GAP_TICKS - 1));
        case (state_q)
            IDLE: begin
                pre_d  = '0;
                tick_d = '0;
                if (start) begin
                    state_d = LOAD;
                    addr_d  = '0;
                end
            end
            LOAD: begin
                pre_d  = '0;
                tick_d = '0;
                if (ent[4:0] == 5'd0) end_song = 1'b1;
                else begin
                    state_d   = PLAY;
                    note_d    = ent[7:5];
                    note_on_d = ent[7:5] != 3'd0;
                end
            end
            PLAY: begin
                if (!last) begin
                    note_d    = note_q;
                    note_on_d = note_on_q;
                end else if (GAP_TICKS == 0) advance = 1'b1;
                else begin
                    state_d = GAP;
                    pre_d   = '0;
                    tick_d  = '0;
                end
            end
            default: advance = last;
        endcase
        if (advance) begin
            if (addr_q == 4'd15) end_song = 1'b1;
            else begin
                state_d = LOAD;
                addr_d  = addr_q + 4'd1;
            end
        end
        if (end_song) begin
            state_d = loop ? LOAD : IDLE;
            addr_d  = '0;
            done_d  = !loop;
        end
        if (stop) begin
            state_d   = IDLE;
            addr_d    = '0;
            pre_d     = '0;
            tick_d    = '0;
            note_d    = '0;
            note_on_d = 1'b0;
            done_d    = 1'b0;
        end
    end

    // State and registered outputs, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            pre_q     <= '0;
            tick_q    <= '0;
            note_q    <= '0;
            note_on_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            note_q    <= note_d;
            note_on_q <= note_on_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1000000, meaning clk cycles per 10 ms duration tick (100 MHz clock).
REQ-002 The block SHALL have parameter GAP_TICKS, default 1, meaning silent ticks inserted after every note.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; there are no other clock domains.
REQ-004 Port: clk  input  1  system clock, all logic on posedge.
REQ-005 Port: rst  input  1  asynchronous active-low reset.
REQ-006 Port: wr_en  input  1  song-table write strobe.
REQ-007 Port: wr_addr  input  4  song-table entry index 0..15.
REQ-008 Port: wr_data  input  8  entry: [7:5] note code (0 = rest, 1..7 = do..si), [4:0] duration in ticks (0 = end marker).
REQ-009 Port: start  input  1  begin playback from entry 0.
REQ-010 Port: stop  input  1  abort playback.
REQ-011 Port: loop  input  1  restart at entry 0 at end of song instead of finishing.
REQ-012 Port: note  output  3  note code for the downstream tone generator, 0 when silent.
REQ-013 Port: note_on  output  1  high while a non-rest note sounds.
REQ-014 Port: busy  output  1  high in any state except IDLE.
REQ-015 Port: done  output  1  one-cycle pulse on normal song completion.
REQ-016 Port: cur_addr  output  4  index of the entry being played.

Function
REQ-017 The song table SHALL be 16 x 8 bits, written on posedge clk when wr_en=1 and state is IDLE; writes in other states are ignored.
REQ-018 The FSM SHALL have states IDLE, LOAD, PLAY, GAP.
REQ-019 IDLE: start=1 -> LOAD with cur_addr=0; start while not IDLE is ignored.
REQ-020 LOAD (exactly 1 cycle): read entry[cur_addr]; duration 0 -> end-of-song handling; else -> PLAY.
REQ-021 PLAY: note = entry note code; note_on = 1 if code != 0, else 0; lasts exactly duration*TICK_DIV cycles.
REQ-022 GAP: note=0, note_on=0, lasts exactly GAP_TICKS*TICK_DIV cycles (0 cycles skipped when GAP_TICKS=0), then cur_addr+1 -> LOAD.
REQ-023 Tick prescaler and tick counter SHALL clear on every entry to PLAY and GAP, so durations are exact and independent of history.
REQ-024 End of song: duration-0 entry in LOAD, or GAP finishing at cur_addr=15 (no 4-bit wrap into entry 0 by itself).
REQ-025 End with loop=1 -> cur_addr=0, LOAD, no done pulse; end with loop=0 -> IDLE, done=1 for one cycle.
REQ-026 Latency: start sampled at edge N -> LOAD after N, PLAY (note valid) after edge N+1.
REQ-027 stop=1 in any state -> IDLE on next edge, note=0, note_on=0, cur_addr=0, no done pulse; stop has priority over start and end-of-song.
REQ-028 Duration counter SHALL be at least 5 bits and prescaler at least ceil(log2(TICK_DIV)) bits; no overflow for duration 31.
REQ-029 note, note_on and done SHALL be registered outputs (glitch-free into the tone generator).

Reset
REQ-030 rst=0 SHALL asynchronously force state IDLE, note=0, note_on=0, busy=0, done=0, cur_addr=0, prescaler and tick counter 0.
REQ-031 Song-table contents SHALL NOT be cleared by reset.
REQ-032 Reset asserted mid-PLAY SHALL silence note_on immediately and leave the block in IDLE after release, requiring a new start.

Verification (TICK_DIV=4, GAP_TICKS=1)
REQ-033 Write entries {0:(1,2),1:(3,1),2:(0,0)}, pulse start -> note=1 for 8 cycles, 0 for 4, note=3 for 4, 0 for 4, then done pulse once, busy=0.
REQ-034 Same table, loop=1 -> sequence 1,3 repeats with no done pulse; stop asserted during second pass -> IDLE next edge, note_on=0.
REQ-035 Entry (0,3) rest -> note=0, note_on=0 for 12 cycles while busy=1 and cur_addr advances correctly.
REQ-036 All 16 entries nonzero duration, loop=0 -> cur_addr runs 0..15, done after entry 15 gap, no entry-0 replay.
REQ-037 wr_en during PLAY with new data -> table unchanged, playback of next entry uses old contents.
REQ-038 rst=0 for 1 cycle mid-note -> outputs zero asynchronously; after release, start replays entry 0 with table intact.
